jtdd2_sub_bridge: RTL and testbench
===================================

// Module: jtdd2_sub_bridge
// PURPOSE
//  Glue between the DD2 main CPU and the Z80 sub-CPU core (core external): 1KB dual-port
//  shared RAM, NMI request latch, main-IRQ request, halt/ROM-wait clock gating and sub
//  address decode. Sits between jtdd_main and the sub Z80; ROM data comes from the SDRAM slot.
// PARAMETERS
//  RAM_AW     10       shared RAM address width (1KB)
//  ROM_TOP    16'hC000 sub addresses below this are ROM
// PORTS
//  clk          in   1   system clock, 48MHz
//  rst          in   1   reset: one clock; reset is synchronous and active-high
//  cen4         in   1   4MHz clock enable for sub CPU
//  main_AB      in   10  main CPU address into shared RAM
//  main_wrn     in   1   main CPU write, active low
//  main_dout    in   8   main CPU write data
//  shared_dout  out  8   shared RAM read data, main port
//  com_cs       in   1   main selects shared RAM
//  mcu_nmi_set  in   1   main requests sub NMI (level, edge-detected)
//  mcu_halt     in   1   main holds sub CPU stopped
//  mcu_irqmain  out  1   one-clk pulse: sub requests main IRQ
//  mcu_ban      out  1   sub occupying shared RAM (main must wait)
//  rom_addr     out  16  sub ROM address; rom_cs out 1; rom_data in 8; rom_ok in 1
//  sub_cen      out  1   gated clock enable to Z80 core
//  sub_addr     in   16  Z80 address; sub_dout in 8; sub_mreq_n/sub_rd_n/sub_wr_n in 1
//  sub_din      out  8   data to Z80
//  sub_nmi_n    out  1   NMI to Z80, active low
// BEHAVIOUR
//  - Reset: shared_dout=0, mcu_irqmain=0, mcu_ban=0, sub_nmi_n=1, rom_cs=0, NMI latch clear.
//    RAM contents not cleared.
//  - Decode when !sub_mreq_n: addr<ROM_TOP ROM; C000-C3FF shared RAM; D000 wr = NMI ack;
//    E000 wr = main IRQ. Other addresses read 8'hFF, writes ignored.
//  - rom_cs = ROM decode && !sub_rd_n; rom_addr = sub_addr. sub_din = rom_data if ROM,
//    else RAM sub-port q, else FF.
//  - sub_cen = cen4 && !mcu_halt && !(rom_cs && !rom_ok); stalls freeze the Z80 exactly.
//  - Shared RAM: true dual port, synchronous read, 1 clk latency both ports.
//    Main write when com_cs && !main_wrn on any clk (not cen-gated).
//    Sub write when RAM decode && !sub_wr_n && sub_cen.
//  - Same-address, same-cycle writes: main data wins; sub data dropped.
//  - NMI: rising edge of mcu_nmi_set sets latch -> sub_nmi_n=0 next clk. Cleared by sub D000
//    write (sub_cen cycle). Set and clear in same clk: set wins.
//  - mcu_irqmain: single-clk pulse on first sub_cen cycle of an E000 write; no repeat while
//    the same write stays asserted.
//  - mcu_halt mid-access: outputs hold, no new writes; resumes on release, no data loss.
//  - rst mid-operation: latches clear next clk, pending ROM request dropped.
// CONFIGURATION
//  JTDD2_SUB_BAN_EN defined: mcu_ban=1 registered while sub decodes shared RAM with mreq low
//    and !mcu_halt; drops 1 clk after access ends.
//  Not defined: mcu_ban tied 0; arbitration is write-collision rule only.
// TESTING
//  - Main writes 8'h5A @10'h123, reads back -> shared_dout=5A one clk after address.
//  - Sub writes A5 @C010, main reads 10'h010 -> A5; same-cycle collision @0x010 main=11,
//    sub=22 -> 11 stored.
//  - mcu_nmi_set 0->1 -> sub_nmi_n=0 next clk; sub write D000 -> sub_nmi_n=1; held high
//    level causes no retrigger.
//  - Sub write E000 held 3 sub cycles -> exactly one 1-clk mcu_irqmain pulse.
//  - Sub read 0x0100 with rom_ok low 20 clks -> sub_cen=0 throughout; rom_ok=1 -> sub_din=rom_data.
//  - mcu_halt=1 -> sub_cen=0 on every cen4; with JTDD2_SUB_BAN_EN, sub RAM read ->
//    mcu_ban=1, else 0.

Source files
------------

// File: rtl/jtdd2_sub_bridge.sv
// DD2 sub-CPU glue: dual-port shared RAM, NMI latch, main IRQ pulse, clock gating, sub decode.
// Optional macro JTDD2_SUB_BAN_EN: drives mcu_ban while the sub CPU occupies shared RAM.
module jtdd2_sub_bridge #(
  parameter int          RAM_AW  = 10,
  parameter logic [15:0] ROM_TOP = 16'hC000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen4,
  input  logic [RAM_AW-1:0] main_AB,
  input  logic              main_wrn,
  input  logic [7:0]        main_dout,
  output logic [7:0]        shared_dout,
  input  logic              com_cs,
  input  logic              mcu_nmi_set,
  input  logic              mcu_halt,
  output logic              mcu_irqmain,
  output logic              mcu_ban,
  output logic [15:0]       rom_addr,
  output logic              rom_cs,
  input  logic [7:0]        rom_data,
  input  logic              rom_ok,
  output logic              sub_cen,
  input  logic [15:0]       sub_addr,
  input  logic [7:0]        sub_dout,
  input  logic              sub_mreq_n,
  input  logic              sub_rd_n,
  input  logic              sub_wr_n,
  output logic [7:0]        sub_din,
  output logic              sub_nmi_n
);
  localparam logic [16:0] RAM_END = 17'(ROM_TOP) + 17'(2**RAM_AW);

  logic [7:0]        mem [0:2**RAM_AW-1];
  logic [7:0]        sub_q;
  logic [RAM_AW-1:0] sub_idx;
  logic              rom_dec, ram_dec, nmi_ack, irq_wr;
  logic              main_we, sub_we;
  logic              nmi_last, irq_done;

  always_comb begin
    sub_idx = sub_addr[RAM_AW-1:0];
    rom_dec = !sub_mreq_n && (sub_addr < ROM_TOP);
    ram_dec = !sub_mreq_n && (sub_addr >= ROM_TOP) && ({1'b0, sub_addr} < RAM_END);
    nmi_ack = !sub_mreq_n && !sub_wr_n && (sub_addr == 16'hD000);
    irq_wr  = !sub_mreq_n && !sub_wr_n && (sub_addr == 16'hE000);
    // A reset cycle drops any pending ROM request immediately
    rom_cs  = rom_dec && !sub_rd_n && !rst;
    sub_cen = cen4 && !mcu_halt && !(rom_cs && !rom_ok);
    main_we = com_cs && !main_wrn;
    // Main port wins a same-address collision; the sub write is discarded
    sub_we  = ram_dec && !sub_wr_n && sub_cen && !(main_we && (main_AB == sub_idx));
    if (rom_dec)      sub_din = rom_data;
    else if (ram_dec) sub_din = sub_q;
    else              sub_din = 8'hFF;
  end

  assign rom_addr = sub_addr;

  always_ff @(posedge clk) begin
    if (main_we) mem[main_AB] <= main_dout;
    if (sub_we)  mem[sub_idx] <= sub_dout;
    sub_q <= mem[sub_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) shared_dout <= 8'h00;
    else     shared_dout <= mem[main_AB];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_last    <= 1'b0;
      sub_nmi_n   <= 1'b1;
      irq_done    <= 1'b0;
      mcu_irqmain <= 1'b0;
    end else begin
      nmi_last <= mcu_nmi_set;
      if (mcu_nmi_set && !nmi_last)  sub_nmi_n <= 1'b0;
      else if (nmi_ack && sub_cen)   sub_nmi_n <= 1'b1;
      // One pulse per E000 write, however long the Z80 holds it
      mcu_irqmain <= irq_wr && sub_cen && !irq_done;
      if (!irq_wr)      irq_done <= 1'b0;
      else if (sub_cen) irq_done <= 1'b1;
    end
  end

`ifdef JTDD2_SUB_BAN_EN
  always_ff @(posedge clk) begin
    if (rst) mcu_ban <= 1'b0;
    else     mcu_ban <= ram_dec && !mcu_halt;
  end
`else
  assign mcu_ban = 1'b0;
`endif

endmodule

// File: tb/tb_jtdd2_sub_bridge.sv
// Directed + randomized bench for jtdd2_sub_bridge against an array model of the shared RAM.
module tb_jtdd2_sub_bridge;
  logic clk = 1'b0;
  logic rst, cen4, main_wrn, com_cs, mcu_nmi_set, mcu_halt, rom_ok;
  logic sub_mreq_n, sub_rd_n, sub_wr_n;
  logic [9:0]  main_AB;
  logic [7:0]  main_dout, rom_data, sub_dout;
  logic [15:0] sub_addr;
  logic [7:0]  shared_dout, sub_din;
  logic        mcu_irqmain, mcu_ban, rom_cs, sub_cen, sub_nmi_n;
  logic [15:0] rom_addr;

  int checks = 0;
  int errors = 0;
  logic [7:0] model [0:1023];

  always #5 clk = ~clk;

  jtdd2_sub_bridge dut (
    .clk(clk), .rst(rst), .cen4(cen4), .main_AB(main_AB), .main_wrn(main_wrn),
    .main_dout(main_dout), .shared_dout(shared_dout), .com_cs(com_cs),
    .mcu_nmi_set(mcu_nmi_set), .mcu_halt(mcu_halt), .mcu_irqmain(mcu_irqmain),
    .mcu_ban(mcu_ban), .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data),
    .rom_ok(rom_ok), .sub_cen(sub_cen), .sub_addr(sub_addr), .sub_dout(sub_dout),
    .sub_mreq_n(sub_mreq_n), .sub_rd_n(sub_rd_n), .sub_wr_n(sub_wr_n),
    .sub_din(sub_din), .sub_nmi_n(sub_nmi_n)
  );

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle;
    cen4 = 0; main_wrn = 1; com_cs = 0; sub_mreq_n = 1; sub_rd_n = 1; sub_wr_n = 1;
  endtask

  task automatic sub_wr(input logic [15:0] a, input logic [7:0] d);
    sub_addr = a; sub_dout = d; sub_mreq_n = 0; sub_wr_n = 0; cen4 = 1;
  endtask

  initial begin
    int pulses;
    logic [7:0] d, d2, rd;
    logic [9:0] a;
    rst = 1; mcu_nmi_set = 0; mcu_halt = 0; rom_ok = 1; rom_data = 8'h00;
    main_AB = 0; main_dout = 0; sub_addr = 16'hF000; sub_dout = 0; idle();
    tick(); tick();
    chk("rst_shared_dout", shared_dout, 8'h00);
    chk("rst_irqmain", mcu_irqmain, 1'b0);
    chk("rst_ban", mcu_ban, 1'b0);
    chk("rst_nmi_n", sub_nmi_n, 1'b1);
    chk("rst_rom_cs", rom_cs, 1'b0);
    rst = 0;

    // main write/readback
    main_AB = 10'h123; main_dout = 8'h5A; com_cs = 1; main_wrn = 0; tick();
    main_wrn = 1; tick();
    chk("main_rdback", shared_dout, 8'h5A);

    // sub write, main read
    idle(); sub_wr(16'hC010, 8'hA5); #2;
    chk("sub_cen_free", sub_cen, 1'b1);
    tick(); idle();
    main_AB = 10'h010; com_cs = 1; tick();
    chk("sub_to_main", shared_dout, 8'hA5);

    // collision: main wins
    main_dout = 8'h11; main_wrn = 0; sub_wr(16'hC010, 8'h22); tick();
    idle(); tick();
    chk("collision_main", shared_dout, 8'h11);
    sub_addr = 16'hC010; sub_mreq_n = 0; sub_rd_n = 0; tick();
    chk("collision_sub_q", sub_din, 8'h11);
    idle();

    // NMI edge, ack, no retrigger on held level
    mcu_nmi_set = 1; tick();
    chk("nmi_set", sub_nmi_n, 1'b0);
    tick(); tick();
    sub_wr(16'hD000, 8'h00); tick(); idle();
    chk("nmi_ack", sub_nmi_n, 1'b1);
    tick(); tick(); tick();
    chk("nmi_no_retrig", sub_nmi_n, 1'b1);
    // ack without sub_cen does nothing
    mcu_nmi_set = 0; tick(); mcu_nmi_set = 1; tick();
    sub_addr = 16'hD000; sub_mreq_n = 0; sub_wr_n = 0; tick(); tick(); idle();
    chk("nmi_ack_needs_cen", sub_nmi_n, 1'b0);
    // set and clear in the same clock: set wins
    mcu_nmi_set = 0; sub_wr(16'hD000, 8'h00); tick(); idle();
    chk("nmi_cleared", sub_nmi_n, 1'b1);
    mcu_nmi_set = 1; sub_wr(16'hD000, 8'h00); tick(); idle();
    chk("nmi_set_wins", sub_nmi_n, 1'b0);
    sub_wr(16'hD000, 8'h00); tick(); idle();
    chk("nmi_cleared2", sub_nmi_n, 1'b1);

    // E000 write held across 3 sub cycles: one pulse
    pulses = 0;
    sub_addr = 16'hE000; sub_mreq_n = 0; sub_wr_n = 0;
    for (int i = 0; i < 12; i++) begin
      cen4 = (i % 4 == 0); tick();
      if (mcu_irqmain) pulses++;
    end
    idle(); tick();
    if (mcu_irqmain) pulses++;
    chk("irq_one_pulse", pulses, 1);

    // ROM stall
    rom_data = 8'($urandom); rom_ok = 0;
    sub_addr = 16'h0100; sub_mreq_n = 0; sub_rd_n = 0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cen4 = i[0]; #2;
      if (sub_cen) pulses++;
      tick();
    end
    chk("rom_stall_cen", pulses, 0);
    chk("rom_cs", rom_cs, 1'b1);
    chk("rom_addr", rom_addr, 16'h0100);
    rom_ok = 1; cen4 = 1; #2;
    chk("rom_ok_cen", sub_cen, 1'b1);
    chk("rom_din", sub_din, rom_data);
    // reset mid-ROM request drops it and clears the NMI latch
    mcu_nmi_set = 0; tick(); mcu_nmi_set = 1; tick();
    rst = 1; #2;
    chk("rst_drops_rom", rom_cs, 1'b0);
    tick(); rst = 0;
    chk("rst_clears_nmi", sub_nmi_n, 1'b1);
    idle(); mcu_nmi_set = 0;
    sub_addr = 16'hF000; sub_mreq_n = 0; sub_rd_n = 0; #2;
    chk("unmapped_ff", sub_din, 8'hFF);
    idle();

    // halt: gating, no sub writes, ban
    main_AB = 10'h020; main_dout = 8'h33; com_cs = 1; main_wrn = 0; tick(); idle();
    mcu_halt = 1; sub_wr(16'hC020, 8'h44); #2;
    chk("halt_cen", sub_cen, 1'b0);
    tick(); tick();
    chk("halt_ban", mcu_ban, 1'b0);
    idle(); main_AB = 10'h020; tick();
    chk("halt_no_write", shared_dout, 8'h33);
    sub_addr = 16'hC020; sub_mreq_n = 0; sub_rd_n = 0; mcu_halt = 0; tick();
`ifdef JTDD2_SUB_BAN_EN
    chk("ban_active", mcu_ban, 1'b1);
`else
    chk("ban_active", mcu_ban, 1'b0);
`endif
    idle(); tick();
    chk("ban_release", mcu_ban, 1'b0);

    // randomized traffic against the array model
    for (int i = 0; i < 1024; i++) begin
      model[i] = 8'($urandom);
      main_AB = 10'(i); main_dout = model[i]; com_cs = 1; main_wrn = 0; tick();
    end
    idle();
    for (int n = 0; n < 400; n++) begin
      a = 10'($urandom); d = 8'($urandom); d2 = 8'($urandom);
      case ($urandom_range(0, 4))
        0: begin
          main_AB = a; main_dout = d; com_cs = 1; main_wrn = 0; tick();
          model[a] = d;
        end
        1: begin
          sub_wr(16'hC000 + 16'(a), d); cen4 = 1'($urandom); tick();
          if (cen4) model[a] = d;
        end
        2: begin
          main_AB = a; main_dout = d; com_cs = 1; main_wrn = 0;
          sub_wr(16'hC000 + 16'(a), d2); tick();
          model[a] = d;
        end
        3: begin
          main_AB = a; com_cs = 1; tick();
          chk("rand_main_rd", shared_dout, model[a]);
        end
        default: begin
          sub_addr = 16'hC000 + 16'(a); sub_mreq_n = 0; sub_rd_n = 0; tick();
          rd = sub_din;
          chk("rand_sub_rd", rd, model[a]);
        end
      endcase
      idle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
